// File: rtl/cordic_scheduler_if.sv
// Requester/response bundle for the shared CORDIC scheduler.
// master = requesters plus response consumer, slave = scheduler.
interface cordic_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int W       = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_mode;
    logic [NUM_REQ-1:0]   req_rot;
    logic [W*NUM_REQ-1:0] req_a;
    logic [W*NUM_REQ-1:0] req_b;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [W-1:0]         rsp_out1;
    logic [W-1:0]         rsp_out2;
    logic                 rsp_err;

    modport master (
        output req_valid, req_mode, req_rot, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_err
    );

    modport slave (
        input  req_valid, req_mode, req_rot, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_err
    );
endinterface

// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one start/done CORDIC core between NUM_REQ
// requesters. Operands stay registered on the core inputs for the whole
// operation, results land in a one-entry response register tagged with the
// requester index. Illegal modes and core timeouts return an error response.
module cordic_scheduler #(
    parameter int NUM_REQ     = 3,
    parameter int FIXED_WIDTH = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    cordic_scheduler_if.slave      bus,
    output logic                   cordic_start_o,
    output logic [1:0]             cordic_mode_o,
    output logic                   cordic_rot_o,
    output logic [FIXED_WIDTH-1:0] cordic_a_o,
    output logic [FIXED_WIDTH-1:0] cordic_b_o,
    input  logic                   cordic_done_i,
    input  logic [FIXED_WIDTH-1:0] cordic_out1_i,
    input  logic [FIXED_WIDTH-1:0] cordic_out2_i,
    output logic                   timeout_flag_o
);
    localparam int W     = FIXED_WIDTH;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_idx, cand;
    logic             grant_valid;
    logic             accept, illegal, start, capture, abort;
    int               sum;

    logic [1:0]       mode_q;
    logic             rot_q;
    logic [W-1:0]     a_q, b_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [W-1:0]     out1_q, out2_q;
    logic             err_q;
    logic             tflag_q;

    logic [1:0]       mode_arr [NUM_REQ];
    logic [W-1:0]     a_arr    [NUM_REQ];
    logic [W-1:0]     b_arr    [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign mode_arr[gi] = bus.req_mode[2*gi +: 2];
            assign a_arr[gi]    = bus.req_a[W*gi +: W];
            assign b_arr[gi]    = bus.req_b[W*gi +: W];
        end
    endgenerate

    // Grant: first valid requester at or after rr_ptr, wrapping; the loop runs
    // downward so the smallest offset from the pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        sum         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = ID_W'(sum);
            if (bus.req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept   = (state_q == S_IDLE) && grant_valid;
    assign illegal  = accept && (mode_arr[grant_idx] == 2'b11);
    assign rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    // Only the granted requester sees ready, and only while idle.
    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_idx] = 1'b1;
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // FSM next state plus the one-cycle strobes that steer the datapath.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        start      = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = illegal ? S_RESP : S_START;
            end
            S_START: begin
                start      = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (cordic_done_i) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch at accept, response capture at done or abort, sticky timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            mode_q   <= '0;
            rot_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_id_q <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            err_q    <= 1'b0;
            tflag_q  <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr_q <= rr_ptr_d;
                rsp_id_q <= grant_idx;
                if (illegal) begin
                    // Core is never started; the last real operands stay on its inputs.
                    err_q  <= 1'b1;
                    out1_q <= '0;
                    out2_q <= '0;
                end else begin
                    mode_q <= mode_arr[grant_idx];
                    rot_q  <= bus.req_rot[grant_idx];
                    a_q    <= a_arr[grant_idx];
                    b_q    <= b_arr[grant_idx];
                end
            end
            if (capture) begin
                out1_q <= cordic_out1_i;
                out2_q <= cordic_out2_i;
                err_q  <= 1'b0;
            end
            if (abort) begin
                out1_q  <= '0;
                out2_q  <= '0;
                err_q   <= 1'b1;
                tflag_q <= 1'b1;
            end
        end
    end

    assign cordic_start_o = start;
    assign cordic_mode_o  = mode_q;
    assign cordic_rot_o   = rot_q;
    assign cordic_a_o     = a_q;
    assign cordic_b_o     = b_q;
    assign timeout_flag_o = tflag_q;

    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_out1   = out1_q;
    assign bus.rsp_out2   = out2_q;
    assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: a behavioural stand-in core (fixed latency per
// mode, results computed from the operands it sees at done) plus a
// transaction-level model of arbitration and responses.
module tb_cordic_scheduler;
    localparam int NR = 3;
    localparam int W  = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_scheduler_if #(.NUM_REQ(NR), .W(W)) bus ();

    logic         cordic_start, cordic_rot, cordic_done, timeout_flag;
    logic [1:0]   cordic_mode;
    logic [W-1:0] cordic_a, cordic_b, cordic_out1, cordic_out2;

    cordic_scheduler #(.NUM_REQ(NR), .FIXED_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .cordic_start_o (cordic_start),
        .cordic_mode_o  (cordic_mode),
        .cordic_rot_o   (cordic_rot),
        .cordic_a_o     (cordic_a),
        .cordic_b_o     (cordic_b),
        .cordic_done_i  (cordic_done),
        .cordic_out1_i  (cordic_out1),
        .cordic_out2_i  (cordic_out2),
        .timeout_flag_o (timeout_flag)
    );

    function automatic logic [15:0] f1(input logic [1:0] m, input logic r,
                                       input logic [15:0] a, input logic [15:0] b);
        return a + b + {13'd0, m, r};
    endfunction

    function automatic logic [15:0] f2(input logic [1:0] m, input logic r,
                                       input logic [15:0] a, input logic [15:0] b);
        return (a ^ {b[14:0], b[15]}) + {8'd0, m, 5'd0, r};
    endfunction

    // Stand-in core: circ/lin done 10 cycles after start, hyp 11.
    int unsigned core_cnt    = 0;
    int          start_count = 0;
    bit          core_en     = 1'b1;
    bit          stray_done  = 1'b0;
    always @(posedge clk) begin
        if (rst) core_cnt <= 0;
        else if (cordic_start) begin
            core_cnt    <= (cordic_mode == 2'b10) ? 11 : 10;
            start_count <= start_count + 1;
        end else if (core_cnt != 0) core_cnt <= core_cnt - 1;
    end
    assign cordic_done = (core_en && core_cnt == 1) || stray_done;
    assign cordic_out1 = f1(cordic_mode, cordic_rot, cordic_a, cordic_b);
    assign cordic_out2 = f2(cordic_mode, cordic_rot, cordic_a, cordic_b);

    typedef struct {
        logic [1:0]  id;
        logic [1:0]  mode;
        logic        rot;
        logic [15:0] a, b, out1, out2;
        logic        err;
    } exp_t;

    int errors = 0;
    int checks = 0;

    bit          pend_v    [NR];
    logic [1:0]  pend_mode [NR];
    logic        pend_rot  [NR];
    logic [15:0] pend_a    [NR];
    logic [15:0] pend_b    [NR];

    task drive_reqs();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]       = pend_v[i];
            bus.req_mode[2*i +: 2] = pend_mode[i];
            bus.req_rot[i]         = pend_rot[i];
            bus.req_a[W*i +: W]    = pend_a[i];
            bus.req_b[W*i +: W]    = pend_b[i];
        end
    endtask

    task set_req(input int i, input logic [1:0] m, input logic r,
                 input logic [15:0] a, input logic [15:0] b);
        pend_v[i] = 1'b1; pend_mode[i] = m; pend_rot[i] = r; pend_a[i] = a; pend_b[i] = b;
    endtask

    task clear_reqs();
        for (int i = 0; i < NR; i++) begin
            pend_v[i] = 1'b0; pend_mode[i] = 2'b00; pend_rot[i] = 1'b0;
            pend_a[i] = 16'h0; pend_b[i] = 16'h0;
        end
        drive_reqs();
    endtask

    task reset_dut();
        rst = 1'b1;
        clear_reqs();
        bus.rsp_ready = 1'b0;
        stray_done = 1'b0;
        core_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one request, sample ready before the edge, withdraw it after.
    task issue(input int i, input logic [1:0] m, input logic r, input logic [15:0] a,
               input logic [15:0] b, output logic [2:0] rdy);
        @(negedge clk);
        set_req(i, m, r, a, b);
        drive_reqs();
        #1;
        rdy = bus.req_ready;
        @(negedge clk);
        pend_v[i] = 1'b0;
        drive_reqs();
    endtask

    task wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task ack();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    function automatic int model_grant(input int ptr);
        for (int k = 0; k < NR; k++)
            if (pend_v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task test_reset();
        rst = 1'b1;
        clear_reqs();
        bus.rsp_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.req_ready, cordic_start, timeout_flag} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0", {bus.rsp_valid, bus.req_ready, cordic_start, timeout_flag});
        end
        checks++;
        if ({cordic_mode, cordic_rot, cordic_a, cordic_b} !== 35'b0) begin
            errors++; $display("FAIL reset_ops got=%h exp=0", {cordic_mode, cordic_rot, cordic_a, cordic_b});
        end
        checks++;
        if ({bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err} !== 35'b0) begin
            errors++; $display("FAIL reset_rsp got=%h exp=0", {bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_req(1, 2'b00, 1'b0, 16'h1, 16'h2);
        set_req(2, 2'b00, 1'b0, 16'h3, 16'h4);
        drive_reqs();
        #1;
        checks++;
        if (bus.req_ready !== 3'b010) begin
            errors++; $display("FAIL reset_first_grant got=%b exp=010", bus.req_ready);
        end
        #1 clear_reqs();
    endtask

    task test_single();
        int n, s0;
        logic [2:0] rdy;
        reset_dut();
        s0 = start_count;
        issue(0, 2'b00, 1'b1, 16'h3244, 16'h0000, rdy);
        checks++;
        if (rdy !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", rdy); end
        wait_rsp(n);
        checks++;
        if (n !== 11) begin errors++; $display("FAIL single_latency got=%0d exp=11", n); end
        checks++;
        if ({bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err} !==
            {2'd0, f1(2'b00, 1'b1, 16'h3244, 16'h0), f2(2'b00, 1'b1, 16'h3244, 16'h0), 1'b0}) begin
            errors++; $display("FAIL single_rsp got=%h %h %h %b exp=0 %h %h 0", bus.rsp_id, bus.rsp_out1,
                               bus.rsp_out2, bus.rsp_err, f1(2'b00, 1'b1, 16'h3244, 16'h0), f2(2'b00, 1'b1, 16'h3244, 16'h0));
        end
        checks++;
        if (start_count - s0 !== 1) begin errors++; $display("FAIL single_starts got=%0d exp=1", start_count - s0); end
        $display("txn single id=%0d out1=%h out2=%h err=%b", bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err);
        ack();
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got=%b exp=0", bus.rsp_valid); end
    endtask

    task test_round_robin();
        int g[$];
        int exp_g[4];
        int cyc;
        exp_g = '{0, 1, 2, 0};
        reset_dut();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 2'b01, 1'b1, 16'(i * 100 + 1), 16'(i + 5));
        cyc = 0;
        while (g.size() < 4 && cyc < 300) begin
            @(negedge clk);
            drive_reqs();
            #1;
            cyc++;
            for (int i = 0; i < NR; i++) if (bus.req_ready[i]) g.push_back(i);
        end
        clear_reqs();
        checks++;
        if (g.size() != 4) begin
            errors++; $display("FAIL rr_count got=%0d exp=4", g.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (g[k] != exp_g[k]) begin errors++; $display("FAIL rr_grant%0d got=%0d exp=%0d", k, g[k], exp_g[k]); end
                else $display("txn rr grant=%0d", g[k]);
            end
        end
    endtask

    task test_linear();
        int n, s0;
        bit stable;
        logic [2:0] rdy;
        reset_dut();
        s0 = start_count;
        stable = 1'b1;
        issue(1, 2'b01, 1'b1, 16'h2000, 16'h6000, rdy);
        checks++;
        if (rdy !== 3'b010) begin errors++; $display("FAIL lin_ready got=%b exp=010", rdy); end
        n = 0;
        while (!bus.rsp_valid && n < 300) begin
            #1;
            if (cordic_start || core_cnt != 0)
                if ({cordic_mode, cordic_rot, cordic_a, cordic_b} !== {2'b01, 1'b1, 16'h2000, 16'h6000}) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL lin_hold got=unstable exp=stable"); end
        checks++;
        if (n !== 11) begin errors++; $display("FAIL lin_latency got=%0d exp=11", n); end
        checks++;
        if ({bus.rsp_id, bus.rsp_out1, bus.rsp_err} !== {2'd1, f1(2'b01, 1'b1, 16'h2000, 16'h6000), 1'b0}) begin
            errors++; $display("FAIL lin_rsp got=%h %h %b exp=1 %h 0", bus.rsp_id, bus.rsp_out1, bus.rsp_err,
                               f1(2'b01, 1'b1, 16'h2000, 16'h6000));
        end
        checks++;
        if (start_count - s0 !== 1) begin errors++; $display("FAIL lin_starts got=%0d exp=1", start_count - s0); end
        $display("txn lin id=%0d out1=%h", bus.rsp_id, bus.rsp_out1);
        ack();
    endtask

    task test_hold();
        int n;
        logic [2:0] rdy;
        logic [15:0] a, b, e1, e2;
        a = 16'($urandom);
        b = 16'($urandom);
        e1 = f1(2'b10, 1'b0, a, b);
        e2 = f2(2'b10, 1'b0, a, b);
        reset_dut();
        issue(2, 2'b10, 1'b0, a, b, rdy);
        checks++;
        if (rdy !== 3'b100) begin errors++; $display("FAIL hold_ready got=%b exp=100", rdy); end
        wait_rsp(n);
        checks++;
        if (n !== 12) begin errors++; $display("FAIL hyp_latency got=%0d exp=12", n); end
        for (int i = 0; i < NR; i++) set_req(i, 2'b00, 1'b0, 16'(i), 16'(i));
        drive_reqs();
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err, bus.req_ready, cordic_start} !==
                {1'b1, 2'd2, e1, e2, 1'b0, 3'b000, 1'b0}) begin
                errors++; $display("FAIL hold_c%0d got=%b %h %h %h %b %b %b exp=1 2 %h %h 0 000 0", c, bus.rsp_valid,
                                   bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err, bus.req_ready, cordic_start, e1, e2);
            end
            @(negedge clk);
        end
        $display("txn hold id=%0d out1=%h out2=%h", bus.rsp_id, bus.rsp_out1, bus.rsp_out2);
        ack();
        #1;
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 4'b0001) begin
            errors++; $display("FAIL hold_next_grant got=%b exp=0001", {bus.rsp_valid, bus.req_ready});
        end
        clear_reqs();
    endtask

    task test_illegal();
        int n, s0;
        logic [2:0] rdy;
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        reset_dut();
        s0 = start_count;
        issue(1, 2'b11, 1'b1, a, b, rdy);
        checks++;
        if (rdy !== 3'b010) begin errors++; $display("FAIL ill_ready got=%b exp=010", rdy); end
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err} !== {1'b1, 2'd1, 32'h0, 1'b1}) begin
            errors++; $display("FAIL ill_rsp got=%b %h %h %h %b exp=1 1 0 0 1", bus.rsp_valid, bus.rsp_id,
                               bus.rsp_out1, bus.rsp_out2, bus.rsp_err);
        end
        checks++;
        if (start_count !== s0) begin errors++; $display("FAIL ill_no_start got=%0d exp=%0d", start_count, s0); end
        $display("txn illegal id=%0d err=%b", bus.rsp_id, bus.rsp_err);
        ack();
        issue(0, 2'b00, 1'b0, a, b, rdy);
        checks++;
        if (rdy !== 3'b001) begin errors++; $display("FAIL ill_next_ready got=%b exp=001", rdy); end
        wait_rsp(n);
        checks++;
        if ({bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err} !==
            {2'd0, f1(2'b00, 1'b0, a, b), f2(2'b00, 1'b0, a, b), 1'b0}) begin
            errors++; $display("FAIL ill_next_rsp got=%h %h %h %b exp=0 %h %h 0", bus.rsp_id, bus.rsp_out1,
                               bus.rsp_out2, bus.rsp_err, f1(2'b00, 1'b0, a, b), f2(2'b00, 1'b0, a, b));
        end
        checks++;
        if (start_count - s0 !== 1) begin errors++; $display("FAIL ill_starts got=%0d exp=1", start_count - s0); end
        ack();
    endtask

    task test_done_ignored();
        reset_dut();
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, cordic_start} !== 2'b00) begin
            errors++; $display("FAIL stray_done got=%b exp=00", {bus.rsp_valid, cordic_start});
        end
    endtask

    task test_timeout();
        int n;
        logic [2:0] rdy;
        reset_dut();
        core_en = 1'b0;
        issue(0, 2'b00, 1'b1, 16'h1111, 16'h2222, rdy);
        wait_rsp(n);
        checks++;
        if (n !== TO + 1) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", n, TO + 1); end
        checks++;
        if ({bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err, timeout_flag} !== {2'd0, 32'h0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL to_rsp got=%h %h %h %b %b exp=0 0 0 1 1", bus.rsp_id, bus.rsp_out1,
                               bus.rsp_out2, bus.rsp_err, timeout_flag);
        end
        $display("txn timeout id=%0d err=%b", bus.rsp_id, bus.rsp_err);
        ack();
        core_en = 1'b1;
        issue(1, 2'b01, 1'b0, 16'h0123, 16'h0456, rdy);
        wait_rsp(n);
        checks++;
        if ({bus.rsp_err, bus.rsp_out1, timeout_flag} !== {1'b0, f1(2'b01, 1'b0, 16'h0123, 16'h0456), 1'b1}) begin
            errors++; $display("FAIL to_sticky got=%b %h %b exp=0 %h 1", bus.rsp_err, bus.rsp_out1, timeout_flag,
                               f1(2'b01, 1'b0, 16'h0123, 16'h0456));
        end
        ack();
        core_en = 1'b0;
        issue(2, 2'b10, 1'b1, 16'h7777, 16'h8888, rdy);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.req_ready, cordic_start, timeout_flag, cordic_mode, cordic_rot, cordic_a, cordic_b} !== 41'b0) begin
            errors++; $display("FAIL rst_mid_wait got=%h exp=0", {bus.rsp_valid, bus.req_ready, cordic_start,
                               timeout_flag, cordic_mode, cordic_rot, cordic_a, cordic_b});
        end
        @(negedge clk);
        rst = 1'b0;
        core_en = 1'b1;
    endtask

    task test_random();
        int got, cyc, g, ptr;
        bit busy;
        logic [2:0] exp_ready;
        exp_t q[$];
        exp_t e;
        reset_dut();
        got = 0; cyc = 0; busy = 1'b0; ptr = 0;
        while (got < 30 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NR; i++)
                if (!pend_v[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            drive_reqs();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = busy ? -1 : model_grant(ptr);
            exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
            checks++;
            if (bus.req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            if (core_cnt != 0 && q.size() != 0) begin
                checks++;
                if ({cordic_mode, cordic_rot, cordic_a, cordic_b} !== {q[0].mode, q[0].rot, q[0].a, q[0].b}) begin
                    errors++; $display("FAIL rand_hold cyc=%0d got=%h exp=%h", cyc, {cordic_mode, cordic_rot, cordic_a, cordic_b},
                                       {q[0].mode, q[0].rot, q[0].a, q[0].b});
                end
            end
            if (bus.rsp_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious cyc=%0d got=rsp_valid exp=none", cyc);
                end else if ({bus.rsp_id, bus.rsp_out1, bus.rsp_out2, bus.rsp_err} !== {q[0].id, q[0].out1, q[0].out2, q[0].err}) begin
                    errors++; $display("FAIL rand_rsp cyc=%0d got=%h %h %h %b exp=%h %h %h %b", cyc, bus.rsp_id, bus.rsp_out1,
                                       bus.rsp_out2, bus.rsp_err, q[0].id, q[0].out1, q[0].out2, q[0].err);
                end
                if (bus.rsp_ready && q.size() != 0) begin
                    $display("txn rand id=%0d mode=%0d out1=%h out2=%h err=%b", q[0].id, q[0].mode, bus.rsp_out1, bus.rsp_out2, bus.rsp_err);
                    void'(q.pop_front());
                    got++;
                    busy = 1'b0;
                end
            end
            if (g >= 0) begin
                e.id   = 2'(g);
                e.mode = pend_mode[g];
                e.rot  = pend_rot[g];
                e.a    = pend_a[g];
                e.b    = pend_b[g];
                e.err  = (pend_mode[g] == 2'b11);
                e.out1 = e.err ? 16'h0 : f1(e.mode, e.rot, e.a, e.b);
                e.out2 = e.err ? 16'h0 : f2(e.mode, e.rot, e.a, e.b);
                q.push_back(e);
                ptr = (g + 1) % NR;
                busy = 1'b1;
                pend_v[g] = 1'b0;
            end
        end
        checks++;
        if (got != 30) begin errors++; $display("FAIL rand_count got=%0d exp=30", got); end
        clear_reqs();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_linear();
        test_hold();
        test_illegal();
        test_done_ignored();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
